// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate truth-table sequencer: state encoding,
// default geometry and the truth-table width helper.
package gate_seq_pkg;

  localparam int DEFAULT_N_IN   = 2;
  localparam int DEFAULT_SETTLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } seq_state_t;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/gate_seq_settle_timer.sv
// Settle counter: load clears it, tick advances it, expired flags the last
// settle cycle of the current input pattern.
module settle_timer #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/gate_tt_sequencer.sv
// Steps an external gate through every input pattern and records its truth
// table; define GATE_SEQ_CMP_EN to add the expected-table compare (pass/fail_idx).
module gate_tt_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN   = DEFAULT_N_IN,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [tt_width(N_IN)-1:0] exp_tt,
  output logic [N_IN-1:0]           gate_in,
  input  logic                      gate_y,
  output logic                      busy,
  output logic                      done,
  output logic [tt_width(N_IN)-1:0] tt,
  output logic                      pass,
  output logic [N_IN-1:0]           fail_idx
);

  localparam int TW = tt_width(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  seq_state_t      state, state_next;
  logic [N_IN-1:0] idx;
  logic            accept, sample, tmr_load, tmr_tick, tmr_expired;

  settle_timer #(.LIMIT(SETTLE)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    tmr_load   = 1'b0;
    tmr_tick   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          tmr_load   = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmr_tick = 1'b1;
        if (tmr_expired) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = ST_FINISH;
        end else begin
          tmr_load   = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign done    = (state == ST_FINISH);
  // The pattern index doubles as the gate drive; it parks on the last pattern after a run.
  assign gate_in = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      tt   <= '0;
      busy <= 1'b0;
    end else if (accept) begin
      idx  <= '0;
      tt   <= '0;
      busy <= 1'b1;
    end else if (sample) begin
      tt[idx] <= gate_y;
      if (idx != LAST_IDX) idx <= idx + 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end
  end

`ifdef GATE_SEQ_CMP_EN
  logic [TW-1:0]   exp_q;
  logic [TW-1:0]   diff;
  logic [N_IN-1:0] first_diff;

  assign diff = tt ^ exp_q;

  always_comb begin
    first_diff = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (diff[i]) first_diff = N_IN'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q    <= '0;
      pass     <= 1'b0;
      fail_idx <= '0;
    end else begin
      if (accept) exp_q <= exp_tt;
      if (done) begin
        pass     <= (diff == '0);
        fail_idx <= first_diff;
      end
    end
  end
`else
  logic unused_exp_tt;

  assign unused_exp_tt = ^exp_tt;
  assign pass          = 1'b0;
  assign fail_idx      = '0;
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Self-checking bench: an abstract edge-count model checked every cycle, plus
// directed runs with hand-computed truth tables, latency, hold and reset checks.
module tb_gate_tt_sequencer;

  localparam int P = 3;   // SETTLE+1 cycles per pattern at the defaults
  localparam int T = 12;  // 4 patterns * P edges until done
`ifdef GATE_SEQ_CMP_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [3:0] exp_tt = 4'b0000;
  logic [1:0] gate_in;
  logic       gate_y;
  logic       busy, done, pass;
  logic [3:0] tt;
  logic [1:0] fail_idx;

  logic       start1 = 1'b0;
  logic [1:0] gate_in1;
  logic       gate_y1, busy1, done1, pass1;
  logic [3:0] tt1;
  logic [1:0] fail_idx1;

  int gate_kind = 0;
  int checks    = 0;
  int errors    = 0;

  always #5 clk = ~clk;

  gate_tt_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_tt(exp_tt), .gate_in(gate_in),
    .gate_y(gate_y), .busy(busy), .done(done), .tt(tt), .pass(pass), .fail_idx(fail_idx)
  );

  gate_tt_sequencer #(.N_IN(2), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(4'b1000), .gate_in(gate_in1),
    .gate_y(gate_y1), .busy(busy1), .done(done1), .tt(tt1), .pass(pass1), .fail_idx(fail_idx1)
  );

  // External gates: 0=AND, 1=OR, otherwise XOR; inputs are {A,B}.
  function automatic logic gate_fn(input int kind, input int p);
    logic [1:0] ab;
    ab = 2'(p);
    case (kind)
      0:       return ab[1] & ab[0];
      1:       return ab[1] | ab[0];
      default: return ab[1] ^ ab[0];
    endcase
  endfunction

  assign gate_y  = gate_fn(gate_kind, int'(gate_in));
  assign gate_y1 = gate_in1[1] & gate_in1[0];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: counts edges since the accepted start and derives every output from that.
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [3:0] m_tt     = 4'b0;
  logic [3:0] m_exp    = 4'b0;
  logic       m_pass   = 1'b0;
  logic [1:0] m_fail   = 2'b0;
  logic [1:0] m_gin    = 2'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_k = 0; m_tt = 4'b0; m_pass = 1'b0; m_fail = 2'b0; m_gin = 2'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k <= T && (m_k % P) == 0) m_tt[2'(m_k / P - 1)] = gate_fn(gate_kind, m_k / P - 1);
      if (m_k < T) m_gin = 2'(m_k / P);
      if (m_k == T + 1) begin
        m_active = 1'b0;
`ifdef GATE_SEQ_CMP_EN
        m_pass = (m_tt == m_exp);
        m_fail = 2'b0;
        for (int i = 3; i >= 0; i--) if (m_tt[i] != m_exp[i]) m_fail = 2'(i);
`else
        m_pass = 1'b0;
        m_fail = 2'b0;
`endif
      end
    end else if (start) begin
      m_active = 1'b1; m_k = 0; m_tt = 4'b0; m_gin = 2'b0; m_exp = exp_tt;
    end
  end

  always @(negedge clk) begin
    checkOutput("gate_in",  32'(gate_in),  32'(m_gin));
    checkOutput("busy",     32'(busy),     32'(m_active));
    checkOutput("done",     32'(done),     32'(m_active && m_k == T));
    checkOutput("tt",       32'(tt),       32'(m_tt));
    checkOutput("pass",     32'(pass),     32'(m_pass));
    checkOutput("fail_idx", 32'(fail_idx), 32'(m_fail));
  end

  // Called at posedge+2; start is seen by the next edge only.
  task automatic applyStimulus(input logic [3:0] expv, input int kind);
    exp_tt    = expv;
    gate_kind = kind;
    start     = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input int kind, input logic [3:0] expv,
                             input logic [3:0] tt_lit, input logic pass_lit, input logic [1:0] fail_lit);
    int lat;
    applyStimulus(expv, kind);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(T));
    @(posedge clk);
    #2;
    checkOutput({tag, "_tt"},       32'(tt),       32'(tt_lit));
    checkOutput({tag, "_pass"},     32'(pass),     32'(pass_lit));
    checkOutput({tag, "_fail_idx"}, 32'(fail_idx), 32'(fail_lit));
    checkOutput({tag, "_busy"},     32'(busy),     32'(0));
  endtask

  task automatic checkSettleOne();
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    checkOutput("s1_gin_k0", 32'(gate_in1), 32'(0));
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checkOutput("s1_done", 32'(done1), 32'(k == 8));
      if (k < 8) checkOutput("s1_gin", 32'(gate_in1), 32'(k / 2));
    end
    @(posedge clk);
    #2;
    checkOutput("s1_tt",   32'(tt1),   32'(4'b1000));
    checkOutput("s1_busy", 32'(busy1), 32'(0));
  endtask

  initial begin
    int n_done;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("reset_gate_in", 32'(gate_in), 32'(0));
    checkOutput("reset_busy",    32'(busy),    32'(0));
    checkOutput("reset_tt",      32'(tt),      32'(0));
    checkOutput("reset_s1_busy", 32'(busy1),   32'(0));

    runAndCheck("and_match", 0, 4'b1000, 4'b1000, CMP_ON, 2'd0);
    runAndCheck("and_miss",  0, 4'b1110, 4'b1000, 1'b0,   CMP_ON ? 2'd1 : 2'd0);
    runAndCheck("xor_match", 2, 4'b0110, 4'b0110, CMP_ON, 2'd0);
    runAndCheck("or_miss",   1, 4'b1000, 4'b1110, 1'b0,   CMP_ON ? 2'd1 : 2'd0);

    // Start held high: accepts at edges 0, 14 and 28, one done each.
    exp_tt = 4'b1000; gate_kind = 0; start = 1'b1; n_done = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      if (c == 29) start = 1'b0;
    end
    checkOutput("held_done_pulses", 32'(n_done), 32'(3));
    @(posedge clk);
    #2;

    // Abort at edge 5 of a run.
    applyStimulus(4'b1000, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_gate_in",  32'(gate_in),  32'(0));
    checkOutput("abort_busy",     32'(busy),     32'(0));
    checkOutput("abort_done",     32'(done),     32'(0));
    checkOutput("abort_tt",       32'(tt),       32'(0));
    checkOutput("abort_pass",     32'(pass),     32'(0));
    checkOutput("abort_fail_idx", 32'(fail_idx), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    checkOutput("abort_no_done", 32'(n_done), 32'(0));
    @(posedge clk);
    #2;
    runAndCheck("after_abort", 0, 4'b1000, 4'b1000, CMP_ON, 2'd0);

    checkSettleOne();

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
